// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_pkg
// Description : Shared defaults and enums for the writeback arbiter slice:
//               register data/number widths, writeback FSM state encoding
//               and the writeback requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

    typedef enum logic [0:0] {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Pending-write scoreboard. One bit per architectural register
//               marks an issued instruction whose result has not yet been
//               written back. Produces the issue stall (RAW on either source,
//               WAW on the destination, or FSM still initialising).
//               Register 0 is hardwired and never becomes pending.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import dlx_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_rd,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_rd,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_init,
    output logic              o_stall
);

    localparam int c_NREG = 2 ** ADDR_W;

    logic [c_NREG-1:0] r_pending;
    logic [c_NREG-1:0] w_pending_nxt;
    logic [c_NREG-1:0] w_set_mask;
    logic [c_NREG-1:0] w_clr_mask;

    // Next pending vector: clear applied first so a same-register set wins.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) begin
            w_set_mask[i_set_rd] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_rd] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_stall = i_init | r_pending[i_rs1] | r_pending[i_rs2] | r_pending[i_rd];

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file writeback arbiter between the ALU and the load
//               unit. Grants at most one writer per cycle, registers the
//               write port (Rd/reg_s/reg_s_enable) one cycle after the grant,
//               and tracks outstanding destinations in a scoreboard to stall
//               decode on hazards.
// Config      : WB_ARB_RR_EN defined   -> round-robin between ALU and load
//               WB_ARB_RR_EN undefined -> fixed priority, load beats ALU
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import dlx_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              stall,
    output logic              WB,
    output logic              reg_s_enable,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] reg_s
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    wb_src_t           w_src;
    logic              w_grant;
    logic              w_init;
    logic              w_set_en;
    logic [ADDR_W-1:0] w_grant_rd;
    logic [DATA_W-1:0] w_grant_data;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef WB_ARB_RR_EN
    wb_src_t r_rr_ptr;

    // Round-robin pointer: after any grant, favour the other requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= SRC_MEM;
        end else if (w_grant) begin
            r_rr_ptr <= (w_src == SRC_MEM) ? SRC_ALU : SRC_MEM;
        end
    end
`endif

    // Next state and arbitration; nothing is granted while initialising.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_src       = SRC_MEM;
        alu_ready   = 1'b0;
        mem_ready   = 1'b0;
        case (r_state)
            INIT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_state_nxt = RUN;
                if (alu_valid || mem_valid) begin
                    w_grant = 1'b1;
`ifdef WB_ARB_RR_EN
                    if (alu_valid && mem_valid) begin
                        w_src = r_rr_ptr;
                    end else begin
                        w_src = mem_valid ? SRC_MEM : SRC_ALU;
                    end
`else
                    w_src = mem_valid ? SRC_MEM : SRC_ALU;
`endif
                    alu_ready = (w_src == SRC_ALU);
                    mem_ready = (w_src == SRC_MEM);
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_init       = (r_state == INIT);
    assign w_grant_rd   = (w_src == SRC_MEM) ? mem_rd   : alu_rd;
    assign w_grant_data = (w_src == SRC_MEM) ? mem_data : alu_data;
    assign w_set_en     = iss_valid && !stall && (iss_rd != '0);

    // Write-port registers: capture the granted request, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            WB           <= 1'b0;
            reg_s_enable <= 1'b0;
            Rd           <= '0;
            reg_s        <= '0;
        end else begin
            WB           <= (w_state_nxt == RUN);
            reg_s_enable <= w_grant && (w_grant_rd != '0);
            if (w_grant) begin
                Rd    <= w_grant_rd;
                reg_s <= w_grant_data;
            end
        end
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_set_en (w_set_en),
        .i_set_rd (iss_rd),
        .i_clr_en (w_grant),
        .i_clr_rd (w_grant_rd),
        .i_rs1    (iss_rs1),
        .i_rs2    (iss_rs2),
        .i_rd     (iss_rd),
        .i_init   (w_init),
        .o_stall  (stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter. Expected values
//               are hand-derived; contention expectations follow the
//               WB_ARB_RR_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef WB_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd, iss_rs1, iss_rs2, iss_rd, Rd;
    logic [DW-1:0] alu_data, mem_data, reg_s;
    logic          iss_valid, stall, WB, reg_s_enable;

    int n_vec;
    int n_err;

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .stall        (stall),
        .WB           (WB),
        .reg_s_enable (reg_s_enable),
        .Rd           (Rd),
        .reg_s        (reg_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        alu_valid = 0; mem_valid = 0; iss_valid = 0;
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
        iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        tick(); tick();
        n_vec++; if (WB !== 1'b0) begin n_err++; $display("FAIL rst_wb: got %b exp 0", WB); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b exp 1", stall); end
        n_vec++; if (reg_s_enable !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b exp 0", reg_s_enable); end
        n_vec++; if (Rd !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d exp 0", Rd); end
        n_vec++; if (reg_s !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h exp 0", reg_s); end
        // release; INIT cycle with both requesters waiting
        reset_n = 1'b1;
        alu_valid = 1; mem_valid = 1; alu_rd = 5'd1; mem_rd = 5'd2;
        #1;
        n_vec++; if (WB !== 1'b0) begin n_err++; $display("FAIL init_wb: got %b exp 0", WB); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL init_stall: got %b exp 1", stall); end
        n_vec++; if ({alu_ready, mem_ready} !== 2'b00) begin n_err++; $display("FAIL init_ready: got %b exp 00", {alu_ready, mem_ready}); end
        tick();
        alu_valid = 0; mem_valid = 0;
        #1;
        n_vec++; if (WB !== 1'b1) begin n_err++; $display("FAIL run_wb: got %b exp 1", WB); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL run_stall: got %b exp 0", stall); end
        n_vec++; if (reg_s_enable !== 1'b0) begin n_err++; $display("FAIL run_en: got %b exp 0", reg_s_enable); end
        tick();
        n_vec++; if (reg_s_enable !== 1'b0) begin n_err++; $display("FAIL idle_en: got %b exp 0", reg_s_enable); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_vec++; if ({alu_ready, mem_ready} !== 2'b10) begin n_err++; $display("FAIL alu_ready: got %b exp 10", {alu_ready, mem_ready}); end
        tick();
        alu_valid = 0;
        n_vec++; if (reg_s_enable !== 1'b1) begin n_err++; $display("FAIL alu_en: got %b exp 1", reg_s_enable); end
        n_vec++; if (Rd !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d exp 5", Rd); end
        n_vec++; if (reg_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_data: got %h exp deadbeef", reg_s); end
        iss_rs1 = 5'd5;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_nopend: got %b exp 0", stall); end
        iss_rs1 = 0;
        tick();
        n_vec++; if (reg_s_enable !== 1'b0) begin n_err++; $display("FAIL alu_idle_en: got %b exp 0", reg_s_enable); end
        n_vec++; if ({Rd, reg_s} !== {5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL alu_hold: got %0d/%h exp 5/deadbeef", Rd, reg_s); end
    endtask

    task automatic test_contention();
        logic          exp_mem;
        logic [AW-1:0] exp_rd;
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2222_0002;
        mem_valid = 1; mem_rd = 5'd1; mem_data = 32'h1111_0001;
        for (int i = 0; i < 4; i++) begin
            exp_mem = c_RR ? (i % 2 == 0) : 1'b1;
            exp_rd  = exp_mem ? 5'd1 : 5'd2;
            #1;
            n_vec++; if ({mem_ready, alu_ready} !== {exp_mem, ~exp_mem}) begin
                n_err++; $display("FAIL cont_ready[%0d]: got mem/alu %b exp %b", i, {mem_ready, alu_ready}, {exp_mem, ~exp_mem});
            end
            tick();
            n_vec++; if (Rd !== exp_rd) begin n_err++; $display("FAIL cont_rd[%0d]: got %0d exp %0d", i, Rd, exp_rd); end
        end
        alu_valid = 0; mem_valid = 0;
        tick();
        n_vec++; if (reg_s_enable !== 1'b0) begin n_err++; $display("FAIL cont_idle: got %b exp 0", reg_s_enable); end
    endtask

    task automatic test_hazard();
        iss_valid = 1; iss_rd = 5'd7;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL haz_issue: got %b exp 0", stall); end
        tick();
        iss_rd = 0; iss_rs1 = 5'd7;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL haz_raw: got %b exp 1", stall); end
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h0000_0077;
        #1;
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL haz_grant: got %b exp 1", mem_ready); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL haz_hold: got %b exp 1", stall); end
        tick();
        mem_valid = 0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL haz_clear: got %b exp 0", stall); end
        n_vec++; if ({reg_s_enable, Rd} !== {1'b1, 5'd7}) begin n_err++; $display("FAIL haz_wr: got %b/%0d exp 1/7", reg_s_enable, Rd); end
        iss_valid = 0; iss_rs1 = 0;
        tick();
    endtask

    task automatic test_same_cycle();
        iss_valid = 1; iss_rd = 5'd3;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        #1;
        n_vec++; if ({stall, alu_ready} !== 2'b01) begin n_err++; $display("FAIL same_pre: got stall/ready %b exp 01", {stall, alu_ready}); end
        tick();
        iss_valid = 0; iss_rd = 0; alu_valid = 0; iss_rs2 = 5'd3;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL same_setwins: got %b exp 1", stall); end
        mem_valid = 1; mem_rd = 5'd3;
        tick();
        mem_valid = 0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL same_clear: got %b exp 0", stall); end
        iss_rs2 = 0;
        tick();
    endtask

    task automatic test_rd_zero();
        iss_valid = 1; iss_rd = 0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL z_issue: got %b exp 0", stall); end
        tick();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL z_after: got %b exp 0", stall); end
        iss_valid = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hCAFEF00D;
        #1;
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL z_ready: got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        n_vec++; if ({reg_s_enable, Rd, reg_s} !== {1'b0, 5'd0, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL z_write: got %b/%0d/%h exp 0/0/cafef00d", reg_s_enable, Rd, reg_s);
        end
        // mid-stream reset pulse
        iss_valid = 1; iss_rd = 5'd9;
        tick();
        iss_valid = 0; iss_rd = 0;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
        tick();
        iss_rs1 = 5'd9;
        #1;
        n_vec++; if ({reg_s_enable, Rd, stall} !== {1'b1, 5'd4, 1'b1}) begin
            n_err++; $display("FAIL prst: got en/rd/stall %b/%0d/%b exp 1/4/1", reg_s_enable, Rd, stall);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if ({WB, reg_s_enable, Rd, reg_s} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL arst_out: got %b/%b/%0d/%h exp 0/0/0/0", WB, reg_s_enable, Rd, reg_s);
        end
        n_vec++; if ({stall, alu_ready} !== 2'b10) begin n_err++; $display("FAIL arst_ctl: got %b exp 10", {stall, alu_ready}); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        n_vec++; if ({stall, alu_ready} !== 2'b10) begin n_err++; $display("FAIL rel_init: got %b exp 10", {stall, alu_ready}); end
        tick();
        alu_valid = 0;
        #1;
        n_vec++; if ({WB, reg_s_enable, stall} !== 3'b100) begin
            n_err++; $display("FAIL rel_run: got wb/en/stall %b exp 100", {WB, reg_s_enable, stall});
        end
        iss_rs1 = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_alu();
        test_contention();
        test_hazard();
        test_same_cycle();
        test_rd_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register number width; register count is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  ALU writeback handshake.
REQ-006 alu_rd / alu_data  input  ADDR_W / DATA_W  ALU destination register and result.
REQ-007 mem_valid / mem_ready  input / output  1 / 1  load-unit writeback handshake.
REQ-008 mem_rd / mem_data  input  ADDR_W / DATA_W  load destination register and data.
REQ-009 iss_valid  input  1  decode issues an instruction this cycle if stall is low.
REQ-010 iss_rs1, iss_rs2, iss_rd  input  ADDR_W each  issuing instruction's sources and destination.
REQ-011 stall  output  1  combinational; issue blocked by a pending write (hazard).
REQ-012 WB  output  1  register-file operate enable, registered.
REQ-013 reg_s_enable  output  1  register-file write enable, registered.
REQ-014 Rd / reg_s  output  ADDR_W / DATA_W  write port register number and data, registered.

Function
REQ-015 FSM states: INIT, RUN; reset enters INIT; INIT -> RUN unconditionally after one clock; WB=0 in INIT, WB=1 in RUN.
REQ-016 In INIT: alu_ready=mem_ready=0, stall=1, no grant, no scoreboard update.
REQ-017 In RUN: at most one requester is granted per cycle; a grant is a valid&&ready transfer.
REQ-018 ready is asserted to exactly the requester selected by the arbitration policy among those with valid high; the other ready is 0.
REQ-019 Grant latency: the granted request appears on reg_s_enable/Rd/reg_s the next cycle; with no grant, reg_s_enable=0 and Rd/reg_s hold.
REQ-020 A granted request with rd=0 yields reg_s_enable=0 (Rd, reg_s still updated).
REQ-021 Scoreboard: pending bit vector of 2**ADDR_W bits; bit 0 is always 0.
REQ-022 Set: iss_valid && !stall && iss_rd!=0 sets pending[iss_rd] on the next edge.
REQ-023 Clear: a grant clears pending[granted rd] on the next edge.
REQ-024 Simultaneous set and clear of the same register: set wins (bit ends 1).
REQ-025 stall = pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd] (WAW included), OR state INIT.
REQ-026 A grant to a non-pending register is legal and leaves the bit 0.

Reset
REQ-027 On reset_n low, immediately: state=INIT, pending all 0, WB=0, reg_s_enable=0, Rd=0, reg_s=0, round-robin pointer points to mem.
REQ-028 Reset mid-transfer discards any in-flight write; no write is issued in the cycle after reset release.

Configuration
REQ-029 With WB_ARB_RR_EN defined: round-robin; after a grant, the pointer moves to the other requester; when both are valid, the pointer's requester wins.
REQ-030 Without WB_ARB_RR_EN: fixed priority, mem beats alu; no pointer register exists.

Structure
REQ-031 Package dlx_pkg holds DATA_W/ADDR_W defaults, the FSM state enum wb_state_t and the requester enum wb_src_t.
REQ-032 Scoreboard is a sub-module wb_scoreboard (pending vector, set/clear, stall); arbitration and output registers stay in wb_arbiter.

Verification
REQ-033 Reset then idle: cycle 0 WB=0, stall=1; cycle 1 WB=1, stall=0; reg_s_enable=0 throughout.
REQ-034 Single ALU write: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle reg_s_enable=1, Rd=5, reg_s=0xDEADBEEF.
REQ-035 Contention: both valid for 4 cycles -> RR build: grants alternate mem, alu, mem, alu; fixed build: mem x4, alu_ready=0.
REQ-036 Hazard: issue rd=7 -> next cycle issue with rs1=7 sees stall=1; grant mem rd=7 -> stall drops the cycle after grant.
REQ-037 Same-cycle issue rd=3 and grant rd=3 -> pending[3]=1 afterwards, stall stays 1 for rs2=3.
REQ-038 rd=0: issue rd=0 never stalls; grant rd=0 -> reg_s_enable=0; reset_n pulse mid-stream clears pending and outputs asynchronously.
